// File: rtl/trade_display.sv
// trade_display: display front end for the trade counter.
// Synchronizes the trade count and halt flag, converts the count to BCD with a
// sequential double-dabble engine, and drives two active-low 7-segment digits
// plus a halt LED. Digits blink while halt is asserted.
// Optional feature macro: TRADE_DISPLAY_BLANK_LZ_EN (leading-zero blanking of hex1).
module trade_display #(
   parameter int unsigned SYNC_STAGES = 2,   // minimum 2
   parameter int unsigned BLINK_BITS  = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] trade_count,
   input  logic       halt_signal,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic       halt_led,
   output logic       busy
);

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
`ifdef TRADE_DISPLAY_BLANK_LZ_EN
   localparam logic [6:0] HEX1_RST  = SEG_BLANK;
`else
   localparam logic [6:0] HEX1_RST  = SEG_ZERO;
`endif

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

   // BCD digit to active-low segments {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   logic [SYNC_STAGES-1:0][7:0] cnt_sync;
   logic [SYNC_STAGES-1:0]      halt_sync;
   logic [7:0]                  cnt_s;
   logic                        halt_s;

   state_t                state_q, state_d;
   logic [7:0]            last_q, last_d;
   logic [19:0]           sr_q, sr_d, sr_adj;
   logic [2:0]            iter_q, iter_d;
   logic [3:0]            tens_q, tens_d, units_q, units_d;
   logic                  ovf_q, ovf_d;
   logic [BLINK_BITS-1:0] blink_q, blink_d;
   logic [6:0]            hex0_q, hex0_d, hex1_q, hex1_d;
   logic                  busy_q, busy_d;

   assign cnt_s  = cnt_sync[SYNC_STAGES-1];
   assign halt_s = halt_sync[SYNC_STAGES-1];

   // Input synchronizer chains; stage 0 captures the asynchronous inputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_sync  <= '0;
         halt_sync <= '0;
      end else begin
         cnt_sync  <= {cnt_sync[SYNC_STAGES-2:0], trade_count};
         halt_sync <= {halt_sync[SYNC_STAGES-2:0], halt_signal};
      end
   end

   // Conversion FSM: snapshot in IDLE, 8 add-3/shift steps, latch digits in DONE
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      sr_d    = sr_q;
      iter_d  = iter_q;
      tens_d  = tens_q;
      units_d = units_q;
      ovf_d   = ovf_q;
      sr_adj  = sr_q;
      if (sr_q[19:16] >= 4'd5) sr_adj[19:16] = sr_q[19:16] + 4'd3;
      if (sr_q[15:12] >= 4'd5) sr_adj[15:12] = sr_q[15:12] + 4'd3;
      if (sr_q[11:8]  >= 4'd5) sr_adj[11:8]  = sr_q[11:8]  + 4'd3;
      unique case (state_q)
         StIdle: begin
            if (cnt_s != last_q) begin
               last_d  = cnt_s;
               sr_d    = {12'b0, cnt_s};
               iter_d  = 3'd0;
               state_d = StShift;
            end
         end
         StShift: begin
            sr_d   = sr_adj << 1;
            iter_d = iter_q + 3'd1;
            if (iter_q == 3'd7) state_d = StDone;
         end
         StDone: begin
            tens_d  = sr_q[15:12];
            units_d = sr_q[11:8];
            ovf_d   = (sr_q[19:16] != 4'd0);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Blink counter free-runs only while halted; output segment selection
   always_comb begin
      blink_d = halt_s ? blink_q + 1'b1 : '0;
      hex0_d  = ovf_d ? SEG_DASH : seg7(units_d);
      hex1_d  = ovf_d ? SEG_DASH : seg7(tens_d);
`ifdef TRADE_DISPLAY_BLANK_LZ_EN
      if (!ovf_d && tens_d == 4'd0) hex1_d = SEG_BLANK;
`endif
      if (blink_d[BLINK_BITS-1]) begin
         hex0_d = SEG_BLANK;
         hex1_d = SEG_BLANK;
      end
      busy_d = (state_d != StIdle);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         last_q  <= '0;
         sr_q    <= '0;
         iter_q  <= '0;
         tens_q  <= '0;
         units_q <= '0;
         ovf_q   <= 1'b0;
         blink_q <= '0;
         hex0_q  <= SEG_ZERO;
         hex1_q  <= HEX1_RST;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         sr_q    <= sr_d;
         iter_q  <= iter_d;
         tens_q  <= tens_d;
         units_q <= units_d;
         ovf_q   <= ovf_d;
         blink_q <= blink_d;
         hex0_q  <= hex0_d;
         hex1_q  <= hex1_d;
         busy_q  <= busy_d;
      end
   end

   assign hex0     = hex0_q;
   assign hex1     = hex1_q;
   assign busy     = busy_q;
   assign halt_led = halt_s;

endmodule
